uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo -- receive-side byte FIFO for a UART receiver.
//
// Buffers bytes from the receiver (rdata_vld/rdata) and presents them to a
// consumer through a show-ahead valid/ready port. Tracks overflow (byte
// dropped on a full FIFO) and receive errors (uart_err) in sticky flags and,
// optionally, 16-bit saturating statistics counters.
//
// Optional feature: define UART_RX_FIFO_STATS_EN to build the ovf_cnt/err_cnt
// counters; otherwise both ports are tied to 0.
//
// Parameters
//   DEPTH        entry count, power of two, 2..256
//   ALMOST_FULL  count threshold for almost_full
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   rdata_vld, rdata    received byte strobe and data
//   uart_err            receiver parity/stop-bit error strobe
//   m_valid, m_ready    consumer handshake; m_data is the head byte
//   count               current occupancy
//   almost_full         registered, high while count >= ALMOST_FULL
//   ovf_flag, err_flag  sticky flags, cleared by clr_flags
//   clr_flags           clears sticky flags and statistics counters
//   ovf_cnt, err_cnt    dropped-byte / receive-error counters
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DEPTH       = 16,
   parameter int ALMOST_FULL = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdata_vld,
   input  logic [7:0]                 rdata,
   input  logic                       uart_err,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [7:0]                 m_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       almost_full,
   output logic                       ovf_flag,
   output logic                       err_flag,
   input  logic                       clr_flags,
   output logic [15:0]                ovf_cnt,
   output logic [15:0]                err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_TH    = CW'(ALMOST_FULL);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_next;
   logic          full, rd_en, wr_en, drop;

   // Full/empty come only from count; pointers alone are ambiguous when equal.
   assign full    = (count == FULL_CNT);
   assign m_valid = (count != '0);
   assign rd_en   = m_valid & m_ready;
   // A full FIFO still accepts a write when a read frees the head this cycle.
   assign wr_en   = rdata_vld & (~full | rd_en);
   assign drop    = rdata_vld & full & ~rd_en;

   assign m_data  = (rst || !m_valid) ? 8'h00 : mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({wr_en, rd_en})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Storage is not reset; a write in the reset cycle is discarded.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wr_ptr] <= rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
         ovf_flag    <= 1'b0;
         err_flag    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count       <= count_next;
         // Built from count_next so the flag lines up with the new count.
         almost_full <= (count_next >= AF_TH);
         // Set events win over a coincident clear.
         ovf_flag    <= drop     | (ovf_flag & ~clr_flags);
         err_flag    <= uart_err | (err_flag & ~clr_flags);
      end
   end

`ifdef UART_RX_FIFO_STATS_EN
   // Saturating counters; an increment coincident with clear yields 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt <= '0;
         err_cnt <= '0;
      end else begin
         if (drop && clr_flags)        ovf_cnt <= 16'd1;
         else if (clr_flags)           ovf_cnt <= '0;
         else if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;

         if (uart_err && clr_flags)    err_cnt <= 16'd1;
         else if (clr_flags)           err_cnt <= '0;
         else if (uart_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
   end
`else
   assign ovf_cnt = '0;
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo -- directed self-checking bench for uart_rx_fifo (DEPTH=16).
// Inputs change 1 time unit after the rising edge; outputs are checked in the
// same window, so every check sees state settled after the preceding edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst, rdata_vld, uart_err, m_ready, clr_flags;
   logic [7:0]  rdata;
   logic        m_valid, almost_full, ovf_flag, err_flag;
   logic [7:0]  m_data;
   logic [4:0]  count;
   logic [15:0] ovf_cnt, err_cnt;

   int checks = 0;
   int errors = 0;

`ifdef UART_RX_FIFO_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   uart_rx_fifo #(.DEPTH(16)) dut (
      .clk(clk), .rst(rst), .rdata_vld(rdata_vld), .rdata(rdata),
      .uart_err(uart_err), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .count(count), .almost_full(almost_full),
      .ovf_flag(ovf_flag), .err_flag(err_flag), .clr_flags(clr_flags),
      .ovf_cnt(ovf_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      rdata_vld = 1'b1;
      rdata     = b;
      tick();
      rdata_vld = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdata_vld = 1'b0; rdata = 8'h00; uart_err = 1'b0;
      m_ready = 1'b0; clr_flags = 1'b0;
      tick(); tick();
      chk("rst_m_data", {24'h0, m_data}, 32'h0);
      rst = 1'b0;
      tick();
      chk("rst_count",   {27'h0, count}, 32'd0);
      chk("rst_m_valid", {31'h0, m_valid}, 32'd0);
      chk("rst_af",      {31'h0, almost_full}, 32'd0);
      chk("rst_flags",   {30'h0, ovf_flag, err_flag}, 32'd0);
      chk("rst_cnts",    {ovf_cnt, err_cnt}, 32'd0);

      // Single byte into empty FIFO: no bypass, visible one cycle later, held.
      rdata_vld = 1'b1; rdata = 8'h55;
      #1 chk("no_bypass", {31'h0, m_valid}, 32'd0);
      tick();
      rdata_vld = 1'b0;
      chk("w55_valid", {31'h0, m_valid}, 32'd1);
      chk("w55_data",  {24'h0, m_data}, 32'h55);
      chk("w55_count", {27'h0, count}, 32'd1);
      tick(); tick();
      chk("w55_hold_valid", {31'h0, m_valid}, 32'd1);
      chk("w55_hold_data",  {24'h0, m_data}, 32'h55);
      m_ready = 1'b1;
      tick();
      chk("w55_read_count", {27'h0, count}, 32'd0);
      chk("w55_read_valid", {31'h0, m_valid}, 32'd0);
      // Read attempt on empty FIFO must not underflow.
      tick();
      chk("empty_read_count", {27'h0, count}, 32'd0);
      m_ready = 1'b0;

      // Fill 0x00..0x0F, then overflow with 0xAA.
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         if (i == 12) chk("af_below", {31'h0, almost_full}, 32'd0);
         if (i == 13) chk("af_at",    {31'h0, almost_full}, 32'd1);
      end
      chk("full_count", {27'h0, count}, 32'd16);
      chk("full_ovf_before", {31'h0, ovf_flag}, 32'd0);
      push(8'hAA);
      chk("ovf_count", {27'h0, count}, 32'd16);
      chk("ovf_flag",  {31'h0, ovf_flag}, 32'd1);
      chk("ovf_cnt",   {16'h0, ovf_cnt}, STATS ? 32'd1 : 32'd0);
      chk("ovf_head",  {24'h0, m_data}, 32'h00);
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain1_%0d", i), {24'h0, m_data}, 32'(i));
         tick();
      end
      m_ready = 1'b0;
      chk("drain1_count", {27'h0, count}, 32'd0);
      chk("drain1_af",    {31'h0, almost_full}, 32'd0);
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      chk("clr_ovf_flag", {31'h0, ovf_flag}, 32'd0);
      chk("clr_ovf_cnt",  {16'h0, ovf_cnt}, 32'd0);

      // Full FIFO, write with simultaneous read: accepted, count unchanged.
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      rdata_vld = 1'b1; rdata = 8'hBB; m_ready = 1'b1;
      tick();
      rdata_vld = 1'b0;
      chk("wr_rd_full_count", {27'h0, count}, 32'd16);
      chk("wr_rd_full_ovf",   {31'h0, ovf_flag}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain2_%0d", i), {24'h0, m_data}, (i < 15) ? 32'h11 + 32'(i) : 32'hBB);
         tick();
      end
      m_ready = 1'b0;
      chk("drain2_count", {27'h0, count}, 32'd0);

      // Error with coincident clear: set wins, no FIFO write.
      uart_err = 1'b1; clr_flags = 1'b1;
      tick();
      uart_err = 1'b0; clr_flags = 1'b0;
      chk("err_clr_flag",  {31'h0, err_flag}, 32'd1);
      chk("err_clr_cnt",   {16'h0, err_cnt}, STATS ? 32'd1 : 32'd0);
      chk("err_no_write",  {27'h0, count}, 32'd0);
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      chk("clr_err_flag", {31'h0, err_flag}, 32'd0);
      chk("clr_err_cnt",  {16'h0, err_cnt}, 32'd0);

      // Reset during a read with count=5 and an error recorded.
      for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
      uart_err = 1'b1; tick(); uart_err = 1'b0;
      chk("pre_rst_count", {27'h0, count}, 32'd5);
      chk("pre_rst_err",   {31'h0, err_flag}, 32'd1);
      m_ready = 1'b1; rst = 1'b1;
      #1 chk("rst_mid_m_data", {24'h0, m_data}, 32'h0);
      tick();
      rst = 1'b0; m_ready = 1'b0;
      chk("rst_mid_count", {27'h0, count}, 32'd0);
      chk("rst_mid_valid", {31'h0, m_valid}, 32'd0);
      chk("rst_mid_flags", {30'h0, ovf_flag, err_flag}, 32'd0);
      chk("rst_mid_cnts",  {ovf_cnt, err_cnt}, 32'd0);

      // Saturation: 65540 dropped bytes.
      for (int i = 0; i < 16; i++) push(8'(i));
      rdata_vld = 1'b1; rdata = 8'hEE;
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      chk("sat_ovf_cnt", {16'h0, ovf_cnt}, STATS ? 32'hFFFF : 32'd0);
      chk("sat_count",   {27'h0, count}, 32'd16);
      chk("sat_flag",    {31'h0, ovf_flag}, 32'd1);
      // Drop coincident with clear: increment wins, counter restarts at 1.
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0; rdata_vld = 1'b0;
      chk("drop_clr_cnt",  {16'h0, ovf_cnt}, STATS ? 32'd1 : 32'd0);
      chk("drop_clr_flag", {31'h0, ovf_flag}, 32'd1);
      chk("head_intact",   {24'h0, m_data}, 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
